// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the multiplexed BCD 7-segment display.
package bcd_disp_pkg;

  // Logical active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam int unsigned MAX_DIGITS = 8;

  // Bit i set when digit i (i>0) and every digit above it are zero.
  // Digit 0 is never blanked; codes 10..15 count as non-zero.
  function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
    input logic [4*MAX_DIGITS-1:0] bcd,
    input int unsigned             ndig
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  zero_run;
    m        = '0;
    zero_run = 1'b1;
    for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < ndig) begin
        zero_run = zero_run && (bcd[4*i +: 4] == 4'd0);
        m[i]     = zero_run;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to logical active-high 7-segment decoder.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digits 0..9 map to numerals; anything else shows a dash
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 7-segment driver: shadow register, refresh prescaler,
// rotating digit scanner, leading-zero blanking and a ghost-blank cycle
// at the start of every slot.
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 1000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGITS - 1);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  logic [PW-1:0]            presc, presc_nxt;
  logic [SW-1:0]            slot, slot_nxt;
  logic [DIGITS-1:0][3:0]   shadow;
  logic [3:0]               digit;
  logic [6:0]               digit_seg;
  logic [MAX_DIGITS-1:0]    blank_all;
  logic [DIGITS-1:0]        blank;
  logic [6:0]               seg_l;
  logic [DIGITS-1:0]        an_l;

  // Prescaler and slot next-state; both hold while the scan is disabled
  always_comb begin
    presc_nxt = presc;
    slot_nxt  = slot;
    if (en) begin
      if (presc == PRESC_LAST) begin
        presc_nxt = '0;
        slot_nxt  = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end
  end

  // Outputs are computed from the next scan position and the current
  // (pre-load) shadow, so a load on the same edge never tears a digit.
  assign digit = shadow[slot_nxt];

  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (digit_seg)
  );

  // Leading-zero mask over the shadow contents
  always_comb begin
    blank_all = '0;
    if (BLANK_LEADING != 0)
      blank_all = lz_blank_mask((4*MAX_DIGITS)'(shadow), DIGITS);
    blank = blank_all[DIGITS-1:0];
  end

  // Logical output pattern: dark on disable, ghost-blank cycle or blanked digit
  always_comb begin
    seg_l = SEG_OFF;
    an_l  = '0;
    if (en && (presc_nxt != '0) && !blank[slot_nxt]) begin
      an_l[slot_nxt] = 1'b1;
      seg_l          = digit_seg;
    end
  end

  // State and output registers; polarity is applied only here
  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      slot   <= '0;
      shadow <= '0;
      an     <= {DIGITS{POL}};
      seg    <= {7{POL}};
    end else begin
      presc <= presc_nxt;
      slot  <= slot_nxt;
      if (load)
        shadow <= bcd_in;
      an    <= an_l ^ {DIGITS{POL}};
      seg   <= seg_l ^ {7{POL}};
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench: two instances (active-high and active-low outputs) share
// all inputs; each expectation is checked in logical form against the first
// and inverted against the second.
module tb_bcd_display_mux;

  logic        clk;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] bcd_in;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;

  int vectors     = 0;
  int miscompares = 0;

  bcd_display_mux #(
    .DIGITS        (4),
    .REFRESH_DIV   (4),
    .ACTIVE_LOW    (0),
    .BLANK_LEADING (1)
  ) u_hi (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .load   (load),
    .bcd_in (bcd_in),
    .seg    (seg0),
    .an     (an0)
  );

  bcd_display_mux #(
    .DIGITS        (4),
    .REFRESH_DIV   (4),
    .ACTIVE_LOW    (1),
    .BLANK_LEADING (1)
  ) u_lo (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .load   (load),
    .bcd_in (bcd_in),
    .seg    (seg1),
    .an     (an1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n edges, checking both instances 1 time unit after each edge
  task automatic run(input int n, input logic [3:0] ea, input logic [6:0] es,
                     input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      assert ({an0, seg0} === {ea, es})
      else begin
        miscompares++;
        $error("FAIL %s[%0d] hi: an=%b seg=%h expected an=%b seg=%h",
               tag, i, an0, seg0, ea, es);
      end
      vectors++;
      assert ({an1, seg1} === {~ea, ~es})
      else begin
        miscompares++;
        $error("FAIL %s[%0d] lo: an=%b seg=%h expected an=%b seg=%h",
               tag, i, an1, seg1, ~ea, ~es);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    bcd_in = 16'h0000;
    run(1, 4'b0000, 7'h00, "reset");

    // Load 1234 with scan on; first lit cycle still shows the cleared shadow
    reset  = 1'b0;
    en     = 1'b1;
    load   = 1'b1;
    bcd_in = 16'h1234;
    run(1, 4'b0001, 7'h3F, "preload");
    load = 1'b0;
    run(2, 4'b0001, 7'h66, "s0");
    run(1, 4'b0000, 7'h00, "blank1");
    run(3, 4'b0010, 7'h4F, "s1");
    run(1, 4'b0000, 7'h00, "blank2");
    run(3, 4'b0100, 7'h5B, "s2");
    run(1, 4'b0000, 7'h00, "blank3");
    run(3, 4'b1000, 7'h06, "s3");
    run(1, 4'b0000, 7'h00, "blank0");
    run(3, 4'b0001, 7'h66, "s0wrap");
    run(1, 4'b0000, 7'h00, "blank1b");
    run(3, 4'b0010, 7'h4F, "s1b");
    run(1, 4'b0000, 7'h00, "blank2b");
    run(1, 4'b0100, 7'h5B, "s2b");

    // Reset mid-scan in slot 2; scan restarts at slot 0 with shadow cleared
    reset = 1'b1;
    run(2, 4'b0000, 7'h00, "rst_mid");
    reset = 1'b0;
    run(1, 4'b0001, 7'h3F, "post_rst");

    // Leading zeros: 0070
    load   = 1'b1;
    bcd_in = 16'h0070;
    run(1, 4'b0001, 7'h3F, "lz_ld");
    load = 1'b0;
    run(1, 4'b0001, 7'h3F, "lz_s0");
    run(1, 4'b0000, 7'h00, "lz_b1");
    run(3, 4'b0010, 7'h07, "lz_s1");
    run(9, 4'b0000, 7'h00, "lz_s23");
    run(3, 4'b0001, 7'h3F, "lz_s0b");

    // All zeros: only digit 0 lit
    load   = 1'b1;
    bcd_in = 16'h0000;
    run(1, 4'b0000, 7'h00, "z_ld");
    load = 1'b0;
    run(12, 4'b0000, 7'h00, "z_blank");
    run(3, 4'b0001, 7'h3F, "z_s0");

    // Invalid code in digit 1 shows a dash and is not treated as zero
    load   = 1'b1;
    bcd_in = 16'h00A0;
    run(1, 4'b0000, 7'h00, "inv_ld");
    load = 1'b0;
    run(3, 4'b0010, 7'h40, "inv_s1");
    run(9, 4'b0000, 7'h00, "inv_s23");
    run(3, 4'b0001, 7'h3F, "inv_s0");

    // Enable gating at presc=2 of slot 1
    load   = 1'b1;
    bcd_in = 16'h1234;
    run(1, 4'b0000, 7'h00, "en_ld");
    load = 1'b0;
    run(2, 4'b0010, 7'h4F, "en_s1");
    en = 1'b0;
    run(2, 4'b0000, 7'h00, "en_off");
    en = 1'b1;
    run(1, 4'b0010, 7'h4F, "en_resume");
    run(1, 4'b0000, 7'h00, "en_blank2");
    run(3, 4'b0100, 7'h5B, "en_s2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Consumes packed BCD digits from a cascade of mod-10 synchronous counters.
- Drives a time-multiplexed common-anode/cathode 7-segment display.
- Contains a load-strobed shadow register, a refresh prescaler, a rotating digit-slot scanner, leading-zero blanking and an anti-ghost blank cycle.
- Sits directly downstream of the decade counter chain, between the counters and the board display pins.

Parameters:
- DIGITS, 4: number of BCD digits and anode lines; legal range 2..8.
- REFRESH_DIV, 1000: clock cycles per digit slot; must be at least 2.
- ACTIVE_LOW, 1: when 1, seg and an are inverted at the output registers.
- BLANK_LEADING, 1: when 1, enables leading-zero suppression.

Ports:
- clk, input, 1: rising-edge clock. This is the only clock.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: scan enable.
- load, input, 1: captures bcd_in into the shadow register.
- bcd_in, input, 4*DIGITS: packed BCD; digit i is bcd_in[4i+3:4i]; digit 0 is least significant.
- seg, output, 7: segment pattern {g,f,e,d,c,b,a}; registered.
- an, output, DIGITS: one-hot digit enable; registered.

Behaviour:
- All state, including outputs, updates on the rising edge of clk only. There are no combinational paths from inputs to outputs.
- State elements:
  - presc: width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1.
  - slot: width $clog2(DIGITS); counts 0..DIGITS-1.
  - shadow: 4*DIGITS bits.
- Reset, checked first and overriding everything else:
  - presc=0, slot=0, shadow=0.
  - an is all inactive (0 logical) and seg is all off (0 logical). Polarity is applied per ACTIVE_LOW.
  - Reset asserted mid-scan discards the scan position. The first slot after reset release is slot 0.
- Load:
  - On an edge with load=1, shadow is loaded from bcd_in. This happens independently of en.
  - The output registers use shadow as it was before the edge, so a loaded value reaches seg on the second edge after load is sampled.
- Prescaler and slot (en=1):
  - presc increments each edge.
  - When presc=REFRESH_DIV-1, presc wraps to 0 and slot advances. Slot DIGITS-1 wraps to 0.
- Output registers (en=1) are loaded from the next-state (presc', slot'):
  - If presc'=0 (ghost-blank cycle): an=0 and seg=0.
  - Otherwise, an has bit slot' set, and seg = decode(shadow digit slot').
  - If that digit is leading-zero-blanked, an=0 and seg=0.
  - Result: each slot is 1 blank cycle followed by REFRESH_DIV-1 lit cycles.
- en=0:
  - presc and slot hold.
  - an=0 and seg=0 from the next edge.
  - When en is reasserted, the scan resumes from the held presc/slot.
- Decode, logical active-high:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Codes 10..15 decode to 0x40 (dash).
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i>0 is blanked iff digit i and every higher digit equal 0.
  - Digit 0 is never blanked.
  - An invalid code counts as non-zero.
- Simultaneous load and slot change: the output uses the pre-load shadow for that edge. No tearing occurs within a single edge.

Decomposition:
- Package bcd_disp_pkg holds:
  - the ten segment constants, SEG_DASH=7'h40 and SEG_OFF=7'h00;
  - a function computing the leading-zero blank mask.
- Sub-module bcd_to_7seg: purely combinational 4-bit to 7-bit decoder, active-high logical. It is also reusable elsewhere.
- Polarity inversion lives only at the top-level output registers.

Test Plan (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0, BLANK_LEADING=1 unless stated):
- Reset: hold reset 2 cycles mid-scan (slot=2) -> an=0000 and seg=0x00 on the first reset edge. After release, the first lit cycle is an=0001.
- Scan: load 0x1234, en=1 -> repeating pattern per slot of {blank, 3 lit cycles}:
  - an=0001 with seg=0x66;
  - an=0010 with seg=0x4F;
  - an=0100 with seg=0x5B;
  - an=1000 with seg=0x06;
  - then wrap to an=0001.
- Leading zeros: load 0x0070 -> slots 3 and 2 stay an=0000; slot1 seg=0x07; slot0 seg=0x3F. Load 0x0000 -> only slot0 lit, with seg=0x3F.
- Invalid code: load 0x00A0 -> slot1 seg=0x40 with an=0010; slots 3 and 2 blanked; slot0 seg=0x3F.
- Enable gating: drop en at presc=2 of slot1 -> an=0000 and seg=0 next edge, presc/slot frozen. On re-enable, an=0010 resumes and lasts the remaining lit cycle before slot2's blank cycle.
- Polarity: ACTIVE_LOW=1 with 0x1234 -> slot0 an=1110 with seg=0x19, and the blank cycle gives an=1111 with seg=0x7F.
